cmp_search_ctrl: RTL
====================

// Module: cmp_search_ctrl
// PURPOSE
//  Initiator for the comparator interface: drives a probe value onto a comparator's A input
//  and consumes its eq/gt/lt flags to find the unknown B operand by binary search.
//  Sits beside comparator_4bit; used in SAR-style searches and threshold finding.
//  Start/done handshake to the host; never more than WIDTH+1 compare cycles per search.
// PARAMETERS
//  WIDTH  4  operand width; search space is 0 .. 2**WIDTH-1
// PORTS
//  clk     in   1                  single clock, rising edge
//  rst     in   1                  synchronous, active-high reset
//  start   in   1                  begin search; sampled only in IDLE
//  probe   out  WIDTH              value driven to comparator input a
//  eq      in   1                  comparator flag: probe == unknown
//  gt      in   1                  comparator flag: probe >  unknown
//  lt      in   1                  comparator flag: probe <  unknown
//  busy    out  1                  high in SEARCH
//  done    out  1                  one-cycle pulse when a search ends (found or error)
//  result  out  WIDTH              found value; held until next accepted start
//  error   out  1                  search ended without a valid find; held like result
//  iters   out  $clog2(WIDTH+2)    compare cycles consumed by the last search
// BEHAVIOUR
//  Reset: state=IDLE; probe, busy, done, result, error, iters all 0. Applies mid-search too.
//  States: IDLE -> SEARCH on start; SEARCH -> DONE on eq or error; DONE -> IDLE always.
//  Accepted start: lo=0, hi=2**WIDTH-1, probe=(lo+hi)>>1, iters=0, error=0, result=0.
//  The comparator is combinational: the flags for the current probe are sampled on the
//   next rising edge. Each SEARCH cycle is one compare; iters increments once per compare.
//  Per compare (lo/hi are WIDTH+1 bits, unsigned; no wrap):
//   eq only -> result=probe, go DONE.
//   lt only -> lo=probe+1; gt only -> hi=probe-1; probe=(lo'+hi')>>1.
//   Flags not exactly one-hot -> error=1, go DONE.
//   lo'>hi' after update (unknown moved or flags lie) -> error=1, go DONE.
//  Bound: a consistent comparator finds any value in <= WIDTH+1 compares.
//   iters > WIDTH+1 cannot occur; an assertion checks this.
//  done: high for exactly the DONE cycle. busy: high only in SEARCH. probe holds its last
//   value outside SEARCH.
//  start in SEARCH or DONE is ignored, not queued. start and rst together: rst wins.
//  gt at probe=0 makes hi' negative. Detect it via the WIDTH+1-bit compare (lo'>hi') or
//   through the extra bit -> error.
// STRUCTURE
//  Package cmp_pkg: state enum {IDLE,SEARCH,DONE}; localparam MAX_ITERS=WIDTH+1;
//   function flags_onehot(eq,gt,lt).
//  Single module with no sub-module. Next-state logic and the midpoint datapath are in one
//   always_ff plus combinational next-value logic.
// TESTING (bench instantiates comparator_4bit with a=probe, b=unknown)
//  unknown=7: start -> one compare, done pulse, result=7, error=0, iters=1.
//  unknown=15: start -> probes 7,11,13,14,15; result=15, iters=5.
//  unknown=0: probes 7,3,1,0; result=0, iters=4. Sweep 0..15, all found with iters<=5.
//  Force eq=gt=1 on first compare -> done with error=1, iters=1, result=0.
//  Change unknown 15->0 mid-search -> error=1 via lo>hi, done pulses, busy drops.
//  rst during SEARCH -> next cycle all outputs 0, IDLE. start during busy ignored.
//   A new start after done begins a clean search.

Source files
------------

// File: rtl/cmp_pkg.sv
// Package for the comparator-driven binary search controller.
// Holds the FSM state encoding, the default operand width with its
// compare-count bound, and the helper that validates comparator flags.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 4;
  // A consistent comparator lets the search converge within WIDTH+1 compares.
  localparam int MAX_ITERS     = WIDTH_DEFAULT + 1;

  // Exactly one of eq/gt/lt must be asserted for a meaningful compare.
  function automatic logic flags_onehot(input logic eq, input logic gt, input logic lt);
    return ({eq, gt, lt} == 3'b100) || ({eq, gt, lt} == 3'b010) ||
           ({eq, gt, lt} == 3'b001);
  endfunction

endpackage

// File: rtl/cmp_search_ctrl.sv
// cmp_search_ctrl: binary-search initiator for an external combinational comparator.
// Drives probe onto the comparator's A input and narrows [lo, hi] from the
// eq/gt/lt flags until the unknown B operand is found or the flags turn out
// to be inconsistent.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start      begin a search; only accepted in IDLE
//   probe      value presented to comparator input a
//   eq, gt, lt comparator flags for the current probe
//   busy       high while searching
//   done       one-cycle pulse when a search ends
//   result     found value, held until the next accepted start
//   error      search ended without a valid find, held like result
//   iters      compare cycles consumed by the last search
//   dbg_state  current FSM state
//
// Handshake: a start pulse seen in IDLE is accepted on that rising edge; busy
// rises the next cycle and stays high for one cycle per compare; done then
// pulses for exactly one cycle with result/error/iters already valid.
// start outside IDLE is dropped, not queued.
module cmp_search_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [WIDTH-1:0]             probe,
  input  logic                         eq,
  input  logic                         gt,
  input  logic                         lt,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             result,
  output logic                         error,
  output logic [$clog2(WIDTH+2)-1:0]   iters,
  output state_t                       dbg_state
);

  localparam int IW       = $clog2(WIDTH+2);
  localparam int ITER_MAX = WIDTH + 1;

  // lo/hi carry one extra bit so probe+1 and probe-1 never wrap silently.
  state_t           state, state_n;
  logic [WIDTH:0]   lo, lo_n, hi, hi_n;
  logic [WIDTH-1:0] probe_n, result_n;
  logic             error_n;
  logic [IW-1:0]    iters_n;
  logic [WIDTH:0]   lo_c, hi_c;

  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] a,
                                                input logic [WIDTH:0] b);
    logic [WIDTH+1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return WIDTH'(s >> 1);
  endfunction

  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    probe_n  = probe;
    result_n = result;
    error_n  = error;
    iters_n  = iters;
    lo_c     = lo;
    hi_c     = hi;

    case (state)
      IDLE: begin
        if (start) begin
          state_n  = SEARCH;
          lo_n     = '0;
          hi_n     = {1'b0, {WIDTH{1'b1}}};
          probe_n  = midpoint('0, {1'b0, {WIDTH{1'b1}}});
          iters_n  = '0;
          error_n  = 1'b0;
          result_n = '0;
        end
      end
      SEARCH: begin
        iters_n = iters + IW'(1);
        if (lt) lo_c = {1'b0, probe} + (WIDTH+1)'(1);
        if (gt) hi_c = {1'b0, probe} - (WIDTH+1)'(1);
        if (!flags_onehot(eq, gt, lt)) begin
          error_n = 1'b1;
          state_n = DONE;
        end else if (eq) begin
          result_n = probe;
          state_n  = DONE;
        end else if ((lo_c > hi_c) || hi_c[WIDTH]) begin
          // Range collapsed (unknown moved or flags lie), or gt at probe 0
          // pushed hi below zero and set the extra bit.
          error_n = 1'b1;
          state_n = DONE;
        end else begin
          lo_n    = lo_c;
          hi_n    = hi_c;
          probe_n = midpoint(lo_c, hi_c);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      probe  <= '0;
      result <= '0;
      error  <= 1'b0;
      iters  <= '0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      probe  <= probe_n;
      result <= result_n;
      error  <= error_n;
      iters  <= iters_n;
    end
  end

  assign busy      = (state == SEARCH);
  assign done      = (state == DONE);
  assign dbg_state = state;

  a_iters_bound : assert property (@(posedge clk) disable iff (rst)
                                   iters <= IW'(ITER_MAX));

endmodule
